rom_addr_sequencer: RTL and testbench

Upstream driver for the six-ROM concatenator stage. It walks a 16-bit index range and splits each index into the six ROM address buses. It waits a programmable settle time, then captures the concatenator's 32-bit result. Each captured word is presented to a downstream consumer over a valid/ready handshake.

---
 rtl/rom_addr_sequencer_if.sv | 62 ++++++
 rtl/rom_addr_sequencer.sv | 149 ++++++++++++++
 tb/tb_rom_addr_sequencer.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_addr_sequencer_if.sv
// ---------------------------------------------------------------------------
// rom_addr_sequencer_if
//
// Purpose: groups the sequencer's control, ROM address, ROM result and
// downstream valid/ready signals into one bundle.
//
// Signals:
//   start, abort        sweep control into the sequencer
//   addr_rom1..6        index slices out to the six ROMs
//   rom_data            32-bit concatenated ROM result into the sequencer
//   data_out/valid      captured word offered to the consumer
//   data_ready          consumer accepts data_out
//   busy, done          sweep status
//   checksum            XOR of captured words (only with SEQ_CHECKSUM_EN)
//
// Modports: master = sequencer side, slave = driver/consumer side.
// Optional feature macro: SEQ_CHECKSUM_EN.
// ---------------------------------------------------------------------------
interface rom_addr_sequencer_if;
    logic        start;
    logic        abort;
    logic [4:0]  addr_rom1;
    logic [1:0]  addr_rom2;
    logic [1:0]  addr_rom3;
    logic [1:0]  addr_rom4;
    logic [1:0]  addr_rom5;
    logic [2:0]  addr_rom6;
    logic [31:0] rom_data;
    logic [31:0] data_out;
    logic        data_valid;
    logic        data_ready;
    logic        busy;
    logic        done;

`ifdef SEQ_CHECKSUM_EN
    logic [31:0] checksum;

    modport master (
        input  start, abort, rom_data, data_ready,
        output addr_rom1, addr_rom2, addr_rom3, addr_rom4, addr_rom5, addr_rom6,
        output data_out, data_valid, busy, done, checksum
    );

    modport slave (
        output start, abort, rom_data, data_ready,
        input  addr_rom1, addr_rom2, addr_rom3, addr_rom4, addr_rom5, addr_rom6,
        input  data_out, data_valid, busy, done, checksum
    );
`else
    modport master (
        input  start, abort, rom_data, data_ready,
        output addr_rom1, addr_rom2, addr_rom3, addr_rom4, addr_rom5, addr_rom6,
        output data_out, data_valid, busy, done
    );

    modport slave (
        output start, abort, rom_data, data_ready,
        input  addr_rom1, addr_rom2, addr_rom3, addr_rom4, addr_rom5, addr_rom6,
        input  data_out, data_valid, busy, done
    );
`endif
endinterface

// File: rtl/rom_addr_sequencer.sv
// ---------------------------------------------------------------------------
// rom_addr_sequencer
//
// Purpose: walks the index range START_IDX..END_IDX, drives the six ROM
// address slices from the registered index, waits SETTLE_CYCLES edges for the
// concatenator to settle, captures rom_data and offers it downstream over a
// valid/ready handshake. done pulses once after the last word is consumed.
//
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous, active-high reset
//   bus   rom_addr_sequencer_if.master (control, addresses, data, status)
//
// Optional feature macro: SEQ_CHECKSUM_EN adds bus.checksum, the XOR of every
// word captured since the last accepted start.
// ---------------------------------------------------------------------------
module rom_addr_sequencer #(
    parameter int unsigned START_IDX     = 0,
    parameter int unsigned END_IDX       = 65535,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    rom_addr_sequencer_if.master bus
);

    localparam int unsigned      CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [15:0]      START_L  = 16'(START_IDX);
    localparam logic [15:0]      END_L    = 16'(END_IDX);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_PRESENT = 2'd2
    } state_t;

    state_t           r_state;
    logic [15:0]      r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_data_out;
    logic             r_data_valid;
    logic             r_busy;
    logic             r_done;
`ifdef SEQ_CHECKSUM_EN
    logic [31:0]      r_checksum;
`endif

    logic w_handshake;
    assign w_handshake = r_data_valid & bus.data_ready;

    // Address buses are plain slices of the registered index, so they only
    // move on the edge that updates r_idx.
    assign bus.addr_rom1  = r_idx[4:0];
    assign bus.addr_rom2  = r_idx[6:5];
    assign bus.addr_rom3  = r_idx[8:7];
    assign bus.addr_rom4  = r_idx[10:9];
    assign bus.addr_rom5  = r_idx[12:11];
    assign bus.addr_rom6  = r_idx[15:13];
    assign bus.data_out   = r_data_out;
    assign bus.data_valid = r_data_valid;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
`ifdef SEQ_CHECKSUM_EN
    assign bus.checksum   = r_checksum;
`endif

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values; reset is tested first inside the clocked block, which
    // makes it synchronous and lets it override every other branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
`ifdef SEQ_CHECKSUM_EN
            r_checksum   <= '0;
`endif
        end else begin
            // done is a single-cycle pulse unless re-asserted below.
            r_done <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    // start together with abort is treated as no request.
                    if (bus.start && !bus.abort) begin
                        r_idx   <= START_L;
                        r_cnt   <= CNT_INIT;
                        r_busy  <= 1'b1;
                        r_state <= ST_SETTLE;
`ifdef SEQ_CHECKSUM_EN
                        r_checksum <= '0;
`endif
                    end
                end

                ST_SETTLE: begin
                    if (bus.abort) begin
                        r_busy       <= 1'b0;
                        r_data_valid <= 1'b0;
                        r_state      <= ST_IDLE;
                    end else if (r_cnt == '0) begin
                        r_data_out   <= bus.rom_data;
                        r_data_valid <= 1'b1;
                        r_state      <= ST_PRESENT;
`ifdef SEQ_CHECKSUM_EN
                        r_checksum   <= r_checksum ^ bus.rom_data;
`endif
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end

                ST_PRESENT: begin
                    // abort wins over a same-cycle handshake: the beat is
                    // dropped and the index is left where it was.
                    if (bus.abort) begin
                        r_busy       <= 1'b0;
                        r_data_valid <= 1'b0;
                        r_state      <= ST_IDLE;
                    end else if (w_handshake) begin
                        r_data_valid <= 1'b0;
                        if (r_idx == END_L) begin
                            // Last index: stop here so the index never wraps.
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_idx   <= r_idx + 16'd1;
                            r_cnt   <= CNT_INIT;
                            r_state <= ST_SETTLE;
                        end
                    end
                end

                default: begin
                    r_busy       <= 1'b0;
                    r_data_valid <= 1'b0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_addr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rom_addr_sequencer
//
// Three sequencer instances with different ranges and settle times share the
// control inputs. Each has its own ROM stub (a function of its own address
// buses) and a transaction-level reference model; a compare process checks
// every instance against its model on every falling edge. Directed sections
// add literal expectations for sweep timing, backpressure, slicing, abort,
// reset and the optional checksum; a randomized section follows.
// ---------------------------------------------------------------------------
module tb_rom_addr_sequencer;

    localparam int unsigned A_START = 0,         A_END = 3,         A_SET = 2;
    localparam int unsigned B_START = 16'hFFFF,  B_END = 16'hFFFF,  B_SET = 1;
    localparam int unsigned C_START = 16'h081F,  C_END = 16'h0821,  C_SET = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start;
    logic abort;
    logic ready;
    int   rom_mode;
    bit   chk_en;

    int n_checks = 0;
    int n_pass   = 0;

    rom_addr_sequencer_if if_a ();
    rom_addr_sequencer_if if_b ();
    rom_addr_sequencer_if if_c ();

    // ROM stub: what the concatenator would return for a given index.
    function automatic logic [31:0] rom_fn(input logic [15:0] idx, input int mode);
        case (mode)
            0:       return {16'h0000, idx};
            1:       return 32'h1 << idx;
            default: return {idx ^ 16'hA5C3, ~idx};
        endcase
    endfunction

    logic [15:0] idx_a, idx_b, idx_c;
    assign idx_a = {if_a.addr_rom6, if_a.addr_rom5, if_a.addr_rom4, if_a.addr_rom3, if_a.addr_rom2, if_a.addr_rom1};
    assign idx_b = {if_b.addr_rom6, if_b.addr_rom5, if_b.addr_rom4, if_b.addr_rom3, if_b.addr_rom2, if_b.addr_rom1};
    assign idx_c = {if_c.addr_rom6, if_c.addr_rom5, if_c.addr_rom4, if_c.addr_rom3, if_c.addr_rom2, if_c.addr_rom1};

    assign if_a.start = start;  assign if_a.abort = abort;  assign if_a.data_ready = ready;
    assign if_b.start = start;  assign if_b.abort = abort;  assign if_b.data_ready = ready;
    assign if_c.start = start;  assign if_c.abort = abort;  assign if_c.data_ready = ready;
    assign if_a.rom_data = rom_fn(idx_a, rom_mode);
    assign if_b.rom_data = rom_fn(idx_b, rom_mode);
    assign if_c.rom_data = rom_fn(idx_c, rom_mode);

    rom_addr_sequencer #(.START_IDX(A_START), .END_IDX(A_END), .SETTLE_CYCLES(A_SET)) dut_a (
        .clk(clk), .rst(rst), .bus(if_a));
    rom_addr_sequencer #(.START_IDX(B_START), .END_IDX(B_END), .SETTLE_CYCLES(B_SET)) dut_b (
        .clk(clk), .rst(rst), .bus(if_b));
    rom_addr_sequencer #(.START_IDX(C_START), .END_IDX(C_END), .SETTLE_CYCLES(C_SET)) dut_c (
        .clk(clk), .rst(rst), .bus(if_c));

    // Reference model: a sweep is either inactive, waiting 'age' edges since
    // its index was loaded, or holding a captured word for the consumer.
    typedef struct {
        bit          active;
        bit          valid;
        bit          done;
        int unsigned idx;
        int unsigned age;
        logic [31:0] dout;
        logic [31:0] csum;
    } mdl_t;

    function automatic mdl_t mdl_step(input mdl_t m, input logic r, input logic st, input logic ab,
                                      input logic rdy, input int unsigned s_idx, input int unsigned e_idx,
                                      input int unsigned settle, input int mode);
        mdl_t        n;
        logic [31:0] rom;
        n      = m;
        n.done = 1'b0;
        rom    = rom_fn(16'(m.idx), mode);
        if (r) begin
            n.active = 1'b0; n.valid = 1'b0; n.idx = 0; n.age = 0; n.dout = '0; n.csum = '0;
        end else if (!m.active) begin
            if (st && !ab) begin
                n.active = 1'b1; n.idx = s_idx; n.age = 0; n.csum = '0;
            end
        end else if (ab) begin
            n.active = 1'b0; n.valid = 1'b0;
        end else if (m.valid) begin
            if (rdy) begin
                n.valid = 1'b0;
                if (m.idx == e_idx) begin
                    n.active = 1'b0; n.done = 1'b1;
                end else begin
                    n.idx = m.idx + 1; n.age = 0;
                end
            end
        end else begin
            n.age = m.age + 1;
            if (n.age == settle) begin
                n.valid = 1'b1; n.dout = rom; n.csum = m.csum ^ rom;
            end
        end
        return n;
    endfunction

    function automatic logic [63:0] exp_vec(input mdl_t m);
        return {13'h0, m.active, m.valid, m.done, 16'(m.idx), m.dout};
    endfunction

    logic [63:0] act_a, act_b, act_c;
    assign act_a = {13'h0, if_a.busy, if_a.data_valid, if_a.done, idx_a, if_a.data_out};
    assign act_b = {13'h0, if_b.busy, if_b.data_valid, if_b.done, idx_b, if_b.data_out};
    assign act_c = {13'h0, if_c.busy, if_c.data_valid, if_c.done, idx_c, if_c.data_out};

    mdl_t m_a, m_b, m_c;

    always @(posedge clk) begin
        m_a = mdl_step(m_a, rst, start, abort, ready, A_START, A_END, A_SET, rom_mode);
        m_b = mdl_step(m_b, rst, start, abort, ready, B_START, B_END, B_SET, rom_mode);
        m_c = mdl_step(m_c, rst, start, abort, ready, C_START, C_END, C_SET, rom_mode);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_a", act_a, exp_vec(m_a));
            check("model_b", act_b, exp_vec(m_b));
            check("model_c", act_c, exp_vec(m_c));
`ifdef SEQ_CHECKSUM_EN
            check("model_csum_a", 64'(if_a.checksum), 64'(m_a.csum));
            check("model_csum_c", 64'(if_c.checksum), 64'(m_c.csum));
`endif
        end
    end

    task automatic drain();
        start = 1'b0; abort = 1'b0; ready = 1'b1;
        repeat (40) @(negedge clk);
    endtask

    int          beats_a, beats_b, beats_c, done_a, done_b;
    int          beat_t[4];
    logic [31:0] beat_d[4];
    logic        busy_at_done;
    logic [15:0] idx_b0;
    logic [15:0] exp_idx;

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b1; rom_mode = 0; chk_en = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("reset_a", act_a, 64'h0);
        check("reset_b", act_b, 64'h0);
        check("reset_c", act_c, 64'h0);

        // Basic sweeps: identity data, then one-hot data.
        for (int pass = 0; pass < 2; pass++) begin
            rom_mode = pass;
            ready = 1'b1;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            beats_a = 0; beats_b = 0; beats_c = 0; done_a = -1; done_b = -1;
            busy_at_done = 1'b1; idx_b0 = '0;
            for (int n = 0; n < 40; n++) begin
                if (if_a.data_valid && ready) begin
                    if (beats_a < 4) begin
                        beat_t[beats_a] = n;
                        beat_d[beats_a] = if_a.data_out;
                    end
                    beats_a++;
                end
                if (if_a.done && done_a < 0) begin
                    done_a = n;
                    busy_at_done = if_a.busy;
                end
                if (if_b.data_valid && ready) beats_b++;
                if (if_b.done && done_b < 0) done_b = n;
                if (n == 0) idx_b0 = idx_b;
                if (if_c.data_valid && ready) beats_c++;
                if (pass == 0 && n == 4)
                    check("c_slice_0820",
                          64'({if_c.addr_rom1, if_c.addr_rom2, if_c.addr_rom3, if_c.addr_rom4, if_c.addr_rom5, if_c.addr_rom6}),
                          64'({5'h00, 2'h1, 2'h0, 2'h0, 2'h1, 3'h0}));
                @(negedge clk);
            end
            check("a_beats", 64'(beats_a), 64'(4));
            for (int k = 0; k < 4; k++) begin
                check("a_beat_time", 64'(beat_t[k]), 64'(2 + 3 * k));
                check("a_beat_data", 64'(beat_d[k]), (pass == 0) ? 64'(k) : 64'(32'h1 << k));
            end
            check("a_done_time", 64'(done_a), 64'(12));
            check("a_busy_at_done", 64'(busy_at_done), 64'(0));
            if (pass == 0) begin
                check("b_slices_ffff", 64'({if_b.addr_rom6, if_b.addr_rom5, if_b.addr_rom4, if_b.addr_rom3, if_b.addr_rom2, if_b.addr_rom1}),
                      64'({3'h7, 2'h3, 2'h3, 2'h3, 2'h3, 5'h1F}));
                check("b_first_idx", 64'(idx_b0), 64'(16'hFFFF));
                check("b_beats", 64'(beats_b), 64'(1));
                check("b_done_time", 64'(done_b), 64'(2));
                check("b_idle_after", 64'(if_b.busy), 64'(0));
                check("c_beats", 64'(beats_c), 64'(3));
            end
        end

`ifdef SEQ_CHECKSUM_EN
        check("csum_after_done", 64'(if_a.checksum), 64'(32'h0000000F));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("csum_clear_on_start", 64'(if_a.checksum), 64'(0));
        drain();
`endif

        // Backpressure: first word must sit still while ready is low.
        rom_mode = 0; ready = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            check("bp_hold", 64'({if_a.data_valid, idx_a, if_a.data_out}), 64'({1'b1, 16'h0, 32'h0}));
            @(negedge clk);
        end
        ready = 1'b1;
        @(negedge clk);
        check("bp_advance", 64'({if_a.busy, if_a.data_valid, idx_a}), 64'({1'b1, 1'b0, 16'h1}));
        drain();

        // Abort in SETTLE.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("abort_settle", 64'({if_a.busy, if_a.data_valid, if_a.done}), 64'(0));
            @(negedge clk);
        end

        // Abort coincident with a handshake: beat dropped, index unchanged.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        exp_idx = 16'h0;
        for (int k = 0; k < 3; k++) begin
            check("abort_handshake", 64'({if_a.busy, if_a.data_valid, if_a.done, idx_a}), 64'({3'b000, exp_idx}));
            @(negedge clk);
        end

        // start together with abort in IDLE is ignored.
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("start_abort_idle", 64'({if_a.busy, if_b.busy, if_c.busy}), 64'(0));
        @(negedge clk);

        // Reset held two cycles mid-sweep.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_mid_a", act_a, 64'h0);
        check("reset_mid_b", act_b, 64'h0);
        check("reset_mid_c", act_c, 64'h0);
        rst = 1'b0;
        @(negedge clk);

        // Randomized traffic, checked against the models every cycle.
        repeat (3000) begin
            start = ($urandom_range(0, 7) == 0);
            abort = ($urandom_range(0, 31) == 0);
            ready = ($urandom_range(0, 9) < 7);
            rst   = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 63) == 0) rom_mode = int'($urandom_range(0, 2));
            @(negedge clk);
        end
        rst = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
